// File: rtl/i_serdes_align_pkg.sv
// i_serdes_align_pkg: aligner state encoding and the default training word shared with the I_SERDES benches
package i_serdes_align_pkg;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CHECK  = 3'd1;
   localparam logic [2:0] ST_SLIP   = 3'd2;
   localparam logic [2:0] ST_SETTLE = 3'd3;
   localparam logic [2:0] ST_LOCKED = 3'd4;
   localparam logic [2:0] ST_FAIL   = 3'd5;
   localparam logic [3:0] DEFAULT_TRAIN_PATTERN = 4'hA;
   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      CHECK  = ST_CHECK,
      SLIP   = ST_SLIP,
      SETTLE = ST_SETTLE,
      LOCKED = ST_LOCKED,
      FAIL   = ST_FAIL
   } align_state_t;
endpackage

// File: rtl/i_serdes_align_cnt.sv
// i_serdes_align_cnt: saturating up-counter with synchronous clear (priority) and count enable
module i_serdes_align_cnt #(
   parameter int WIDTH = 4,
   parameter int MAX   = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && cnt != WIDTH'(MAX)) cnt <= cnt + WIDTH'(1);
endmodule

// File: rtl/i_serdes_bitslip_ctrl.sv
// i_serdes_bitslip_ctrl: word-alignment controller for I_SERDES; slips the deserializer boundary
// until the training word locks, then forwards aligned words and watches for loss of lock.
module i_serdes_bitslip_ctrl
   import i_serdes_align_pkg::*;
#(
   parameter int               WIDTH         = 4,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(DEFAULT_TRAIN_PATTERN),
   parameter int               PULSE_CYCLES  = 2,
   parameter int               SETTLE_CYCLES = 3,
   parameter int               LOCK_COUNT    = 8,
   parameter int               LOSS_COUNT    = 4,
   parameter int               MAX_SLIPS     = 8
) (
   input  logic                             CLK_IN,
   input  logic                             RX_RST,
   input  logic                             EN,
   input  logic [WIDTH-1:0]                 Q,
   input  logic                             DATA_VALID,
   output logic                             BITSLIP_ADJ,
   output logic                             ALIGNED,
   output logic                             ALIGN_ERROR,
   output logic [$clog2(MAX_SLIPS+1)-1:0]   SLIP_COUNT,
   output logic [WIDTH-1:0]                 Q_OUT,
   output logic                             DATA_VALID_OUT
);
   localparam int SW   = $clog2(MAX_SLIPS + 1);
   localparam int MW   = $clog2(LOCK_COUNT + 1);
   localparam int LW   = $clog2(LOSS_COUNT + 1);
   localparam int TMAX = PULSE_CYCLES > SETTLE_CYCLES ? PULSE_CYCLES : SETTLE_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   if (WIDTH < 3 || WIDTH > 10 || PULSE_CYCLES < 1 || SETTLE_CYCLES < 1 || LOCK_COUNT < 1 ||
       LOSS_COUNT < 1 || MAX_SLIPS < WIDTH) begin : g_bad_params
      $error("i_serdes_bitslip_ctrl: illegal parameter value");
   end

   align_state_t state, nxt;
   logic [MW-1:0] match_cnt;
   logic [LW-1:0] miss_cnt;
   logic [TW-1:0] tmr;
   logic hit, miss;

   assign hit  = DATA_VALID && Q == TRAIN_PATTERN;
   assign miss = DATA_VALID && Q != TRAIN_PATTERN;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = CHECK;
         CHECK:   nxt = hit && match_cnt == MW'(LOCK_COUNT - 1) ? LOCKED :
                        miss ? (SLIP_COUNT == SW'(MAX_SLIPS) ? FAIL : SLIP) : CHECK;
         SLIP:    nxt = tmr == TW'(PULSE_CYCLES - 1) ? SETTLE : SLIP;
         SETTLE:  nxt = tmr == TW'(SETTLE_CYCLES - 1) ? CHECK : SETTLE;
         LOCKED:  nxt = miss && miss_cnt == LW'(LOSS_COUNT - 1) ? CHECK : LOCKED;
         FAIL:    nxt = FAIL;
         default: nxt = IDLE;
      endcase
      if (!EN) nxt = IDLE;
   end

   i_serdes_align_cnt #(.WIDTH(MW), .MAX(LOCK_COUNT)) u_match (
      .clk(CLK_IN), .rst_n(RX_RST), .clr(nxt != CHECK || miss), .en(state == CHECK && hit),
      .cnt(match_cnt));

   i_serdes_align_cnt #(.WIDTH(LW), .MAX(LOSS_COUNT)) u_miss (
      .clk(CLK_IN), .rst_n(RX_RST), .clr(nxt != LOCKED || hit), .en(miss), .cnt(miss_cnt));

   // a fresh attempt after loss of lock gets the full slip budget again
   i_serdes_align_cnt #(.WIDTH(SW), .MAX(MAX_SLIPS)) u_slip (
      .clk(CLK_IN), .rst_n(RX_RST), .clr(nxt == IDLE || (state == LOCKED && nxt == CHECK)),
      .en(state == CHECK && nxt == SLIP), .cnt(SLIP_COUNT));

   // restarts on every state change, so it times both the pulse and the settle window
   i_serdes_align_cnt #(.WIDTH(TW), .MAX(TMAX)) u_tmr (
      .clk(CLK_IN), .rst_n(RX_RST), .clr(nxt != state), .en(1'b1), .cnt(tmr));

   always_ff @(posedge CLK_IN or negedge RX_RST)
      if (!RX_RST) begin
         state          <= IDLE;
         BITSLIP_ADJ    <= 1'b0;
         ALIGNED        <= 1'b0;
         ALIGN_ERROR    <= 1'b0;
         Q_OUT          <= '0;
         DATA_VALID_OUT <= 1'b0;
      end else begin
         state          <= nxt;
         BITSLIP_ADJ    <= nxt == SLIP;
         ALIGNED        <= nxt == LOCKED;
         ALIGN_ERROR    <= nxt == FAIL;
         Q_OUT          <= Q;
         DATA_VALID_OUT <= DATA_VALID && nxt == LOCKED;
      end
endmodule

// File: tb/tb_i_serdes_bitslip_ctrl.sv
// tb_i_serdes_bitslip_ctrl: directed scenarios against a rotating-boundary deserializer model;
// expected outputs are queued per clock and checked by an independent monitor.
module tb_i_serdes_bitslip_ctrl;
   import i_serdes_align_pkg::*;

   logic       CLK_IN = 1'b0, RX_RST = 1'b0, EN = 1'b0, DATA_VALID = 1'b0;
   logic [3:0] Q = 4'h0;
   logic       BITSLIP_ADJ, ALIGNED, ALIGN_ERROR, DATA_VALID_OUT;
   logic [3:0] SLIP_COUNT, Q_OUT;

   typedef struct {
      int         id;
      logic       bs, al, er, dvo;
      logic [3:0] sc, q;
   } exp_t;

   exp_t       sb[$];
   int         n_chk = 0, n_fail = 0, step_no = 0, off = 0;
   logic [3:0] base = DEFAULT_TRAIN_PATTERN;
   logic       bs_prev = 1'b0;

   always #5 CLK_IN = ~CLK_IN;

   i_serdes_bitslip_ctrl dut (
      .CLK_IN(CLK_IN), .RX_RST(RX_RST), .EN(EN), .Q(Q), .DATA_VALID(DATA_VALID),
      .BITSLIP_ADJ(BITSLIP_ADJ), .ALIGNED(ALIGNED), .ALIGN_ERROR(ALIGN_ERROR),
      .SLIP_COUNT(SLIP_COUNT), .Q_OUT(Q_OUT), .DATA_VALID_OUT(DATA_VALID_OUT));

   function automatic logic [3:0] rotl(input logic [3:0] w, input int k);
      logic [7:0] d;
      d = {w, w};
      return d[7 - (k % 4) -: 4];
   endfunction

   function automatic exp_t mk(input int id, input logic bs, al, er, dvo, input logic [3:0] sc, q);
      exp_t e;
      e.id = id; e.bs = bs; e.al = al; e.er = er; e.dvo = dvo; e.sc = sc; e.q = q;
      return e;
   endfunction

   // drive one clock of stimulus; the deserializer model rotates on each slip rising edge
   task automatic step(input logic en, dv, bs, al, er, input logic [3:0] sc);
      @(negedge CLK_IN);
      if (BITSLIP_ADJ && !bs_prev) off++;
      bs_prev    = BITSLIP_ADJ;
      EN         = en;
      DATA_VALID = dv;
      Q          = rotl(base, off);
      step_no++;
      sb.push_back(mk(step_no, bs, al, er, dv && al, sc, RX_RST ? Q : 4'h0));
   endtask

   task automatic cmp(input string nm, input int id, input logic [3:0] got, want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", nm, id, got, want);
      end
   endtask

   task automatic check(input exp_t e);
      cmp("BITSLIP_ADJ", e.id, {3'b0, BITSLIP_ADJ}, {3'b0, e.bs});
      cmp("ALIGNED", e.id, {3'b0, ALIGNED}, {3'b0, e.al});
      cmp("ALIGN_ERROR", e.id, {3'b0, ALIGN_ERROR}, {3'b0, e.er});
      cmp("SLIP_COUNT", e.id, SLIP_COUNT, e.sc);
      cmp("DATA_VALID_OUT", e.id, {3'b0, DATA_VALID_OUT}, {3'b0, e.dvo});
      cmp("Q_OUT", e.id, Q_OUT, e.q);
   endtask

   always @(posedge CLK_IN) begin
      #1;
      if (sb.size() > 0) check(sb.pop_front());
   end

   always @(negedge RX_RST) begin
      #1;
      if (sb.size() > 0) check(sb.pop_front());
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // reset holds every output low
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      @(negedge CLK_IN) RX_RST = 1'b1;

      // pre-aligned: lock on the 8th evaluated word, no slips
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);

      // valid gaps: idle cycles do not count toward lock
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      for (int v = 1; v <= 8; v++) begin
         step(1'b1, 1'b1, 1'b0, v == 8, 1'b0, 4'd0);
         step(1'b1, 1'b0, 1'b0, v == 8, 1'b0, 4'd0);
      end

      // loss of lock: 3 misses then a hit stays locked; 4 misses drop lock and retrain
      base = 4'h3;
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      base = DEFAULT_TRAIN_PATTERN;
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      base = 4'h3;
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
      repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

      // boundary off by one bit: one 2-clock slip, 3 settle clocks, then lock
      base = DEFAULT_TRAIN_PATTERN;
      off  = 1;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
      repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
      repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
      repeat (2) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);

      // never matches: 8 slips, then sticky failure with SLIP_COUNT held at 8
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      base = 4'h3;
      off  = 0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      for (int t = 1; t <= 51; t++) begin
         if (t < 49) step(1'b1, 1'b1, ((t - 1) % 6) < 2, 1'b0, 1'b0, 4'((t - 1) / 6 + 1));
         else        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);

      // asynchronous reset between edges while the slip pulse is high
      @(posedge CLK_IN);
      #3;
      step_no++;
      sb.push_back(mk(step_no, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0));
      RX_RST = 1'b0;
      repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      @(negedge CLK_IN) RX_RST = 1'b1;
      repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

      repeat (2) @(negedge CLK_IN);
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
